aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
Iterative AES encryption engine controller. It accepts one plaintext/key pair over a valid/ready handshake and runs the AES rounds one per clock on a single shared round datapath, selecting the round key by round counter. It presents the ciphertext over a valid/ready output handshake. It is the area-optimised counterpart of the fully unrolled combinational encryptor, and the expected consumer is a mode wrapper (ECB/CTR) or a bus slave.

Parameters:
key_length, 128, key width in bits; legal values 128/192/256.
Nk, key_length/32, key words; 4/6/8.
Nr, Nk+6, round count; derived, never overridden independently.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  plaintext/key offered.
in_ready  output  1  block can accept; combinational: (state==IDLE) || (state==DONE && out_ready).
plain_txt  input  [0:127]  plaintext; bit 0 = MSB of byte 0.
key  input  [0:key_length-1]  cipher key, same bit order.
out_valid  output  1  cipher_txt valid.
out_ready  input  1  consumer takes the result.
cipher_txt  output  [0:127]  ciphertext register.
busy  output  1  high in RUN.
round_idx  output  [3:0]  current round counter, for debug.

Behaviour:
- Reset (rst_n==0 at a clk edge, from any state including mid-RUN): state=IDLE, round_idx=0, out_valid=0, busy=0, cipher_txt=0, and the key register and state register are cleared. The block in flight is discarded.
- FSM states:
  - IDLE: wait for input.
  - RUN: one round per edge.
  - DONE: hold the result.
- Accept (in_valid && in_ready at an edge):
  - key_reg <= key.
  - state_reg <= plain_txt ^ rk[0].
  - round_idx <= 1.
  - Go to RUN.
  - Inputs are sampled only at this edge; later input changes are ignored.
- Round keys: rk[i] = bits [i*128 +: 128] of the Key_Expansion output driven from key_reg. rk[0] is taken directly from the key input on the accept cycle.
- RUN, each edge:
  - state_reg <= round(state_reg, rk[round_idx]), where round = SubBytes, then ShiftRows, then MixColumns, then AddRoundKey.
  - MixColumns is bypassed when round_idx==Nr.
  - If round_idx<Nr: round_idx++.
  - If round_idx==Nr: go to DONE, out_valid<=1, round_idx<=0.
- Latency: out_valid rises exactly Nr edges after the accept edge (10/12/14). in_valid is ignored while in RUN.
- DONE: cipher_txt == state_reg and is stable while out_valid && !out_ready.
  - out_ready with no new input: IDLE next edge, out_valid<=0.
  - out_ready && in_valid at the same edge: output handshake and input accept both happen; go directly to RUN; out_valid<=0. This gives back-to-back throughput of one block per Nr+1 cycles with no bubble.
- cipher_txt holds its last value after the handshake; it is meaningful only while out_valid=1.
- No arithmetic widths beyond 128-bit XOR. round_idx never exceeds Nr.

Optional Feature:
AES_SEQ_ABORT_EN: adds an input port abort (1 bit).
- With the macro defined:
  - abort=1 at an edge in RUN or DONE: go to IDLE, out_valid<=0, round_idx<=0. cipher_txt is not updated on a RUN abort.
  - abort has priority over the output handshake and over a simultaneous new accept.
  - While abort=1, in_ready=0.
- Without the macro: the port does not exist and the behaviour above is unchanged.

Decomposition:
- Package aes_seq_pkg:
  - typedef of the FSM state enum (IDLE/RUN/DONE).
  - function nr_of(Nk).
  - localparam ROUND_W=4.
  - localparam BLK_W=128.
- Sub-module aes_round: combinational single round (subByte, ShiftRows enc, MixColumns enc with final-round bypass input, AddRoundKey). The sequencer instantiates one aes_round plus Key_Expansion; everything else is FSM, counter and registers.

Test Plan:
- AES-128 (FIPS-197 C.1): key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1 -> out_valid 10 edges after accept, ct 69c4e0d86a7b0430d8cdb78070b4c55a, busy high exactly 10 cycles.
- Key_length=192/256 builds (C.2/C.3, key 0001..17 / 0001..1f, same pt) -> ct dda97ca4864cdfe06eaf70a0ec0d7191 after 12 edges; 8ea2b7ca516745bfeafc49904b496089 after 14 edges.
- Backpressure: FIPS-197 App. B vector (key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734), out_ready=0 for 5 cycles -> ct 3925841d02dc09fbdc118597196a0b32 held stable, in_ready=0 until out_ready rises.
- Back-to-back: in_valid held with two blocks, out_ready=1 -> second accept coincides with first output handshake; second out_valid 10 edges later; no idle cycle.
- Reset at round_idx=5 -> next edge IDLE, out_valid=0, cipher_txt=0, in_ready=1. A fresh block then yields the correct ct.
- AES_SEQ_ABORT_EN: abort at round 3 -> IDLE next edge, no out_valid pulse. Abort in DONE together with out_ready && in_valid -> IDLE, no accept.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared types, widths and GF(2^8) helpers for the iterative AES sequencer.
package aes_seq_pkg;
  localparam int ROUND_W = 4;
  localparam int BLK_W   = 128;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

  // Forward S-box, entry n at bits [n*8 +: 8] (entry 0 leftmost).
  localparam logic [0:2047] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input int j);
    case (j)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-in / block-out valid-ready bus of the AES sequencer.
interface aes_round_sequencer_if
  import aes_seq_pkg::*;
#(
  parameter int key_length = 128
);
  logic                  in_valid;
  logic                  in_ready;
  logic [0:BLK_W-1]      plain_txt;
  logic [0:key_length-1] key;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:BLK_W-1]      cipher_txt;

  modport master (output in_valid, plain_txt, key, out_ready,
                  input  in_ready, out_valid, cipher_txt);
  modport slave  (input  in_valid, plain_txt, key, out_ready,
                  output in_ready, out_valid, cipher_txt);
endinterface

// File: rtl/aes_key_expansion.sv
// Full combinational AES key schedule; rk[i] is the round-i key.
module aes_key_expansion
  import aes_seq_pkg::*;
#(
  parameter  int key_length = 128,
  localparam int nk         = key_length / 32,
  localparam int nr         = nr_of(nk)
) (
  input  logic [0:key_length-1]    key,
  output logic [0:nr][0:BLK_W-1]   rk
);
  localparam int NW = 4 * (nr + 1);

  logic [31:0] w [NW];

  for (genvar i = 0; i < NW; i++) begin : g_w
    if (i < nk) begin : g_key
      assign w[i] = key[i*32 +: 32];
    end else if (i % nk == 0) begin : g_rot
      assign w[i] = w[i-nk] ^ sub_word({w[i-1][23:0], w[i-1][31:24]}) ^ {rcon(i / nk), 24'h0};
    end else if (nk > 6 && i % nk == 4) begin : g_sub
      assign w[i] = w[i-nk] ^ sub_word(w[i-1]);
    end else begin : g_xor
      assign w[i] = w[i-nk] ^ w[i-1];
    end
  end

  for (genvar r = 0; r <= nr; r++) begin : g_rk
    assign rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end
endmodule

// File: rtl/aes_round.sv
// One combinational AES encryption round; last=1 drops MixColumns.
module aes_round
  import aes_seq_pkg::*;
(
  input  logic [0:BLK_W-1] st_in,
  input  logic [0:BLK_W-1] rk,
  input  logic             last,
  output logic [0:BLK_W-1] st_out
);
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb
    for (int i = 0; i < 16; i++) sb[i] = sbox(st_in[i*8 +: 8]);

  // Byte r+4c is row r, column c; row r rotates left by r.
  always_comb
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];

  always_comb
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end

  always_comb
    for (int i = 0; i < 16; i++) st_out[i*8 +: 8] = (last ? sr[i] : mc[i]) ^ rk[i*8 +: 8];
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryptor: one round per clock on a shared round datapath.
// Optional AES_SEQ_ABORT_EN adds an abort input that drops the block in flight.
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int key_length = 128
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef AES_SEQ_ABORT_EN
  input  logic                abort,
`endif
  aes_round_sequencer_if.slave bus,
  output logic                busy,
  output logic [ROUND_W-1:0]  round_idx
);
  localparam int nk = key_length / 32;
  localparam int nr = nr_of(nk);
  localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(nr);

  seq_state_e            state;
  logic [0:key_length-1] key_reg;
  logic [0:BLK_W-1]      state_reg;
  logic [0:BLK_W-1]      round_out;
  logic [0:BLK_W-1]      cipher_q;
  logic                  out_valid_q;
  logic [0:nr][0:BLK_W-1] rk;
  logic                  abort_i;
  logic                  accept;

`ifdef AES_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign bus.in_ready   = !abort_i && (state == IDLE || (state == DONE && bus.out_ready));
  assign bus.out_valid  = out_valid_q;
  assign bus.cipher_txt = cipher_q;
  assign accept         = bus.in_valid && bus.in_ready;

  aes_key_expansion #(.key_length(key_length)) u_kexp (
    .key (key_reg),
    .rk  (rk)
  );

  aes_round u_round (
    .st_in  (state_reg),
    .rk     (rk[round_idx]),
    .last   (round_idx == LAST_RND),
    .st_out (round_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      round_idx   <= '0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      cipher_q    <= '0;
      key_reg     <= '0;
      state_reg   <= '0;
    end else if (abort_i && state != IDLE) begin
      state       <= IDLE;
      round_idx   <= '0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else if (accept) begin
      // rk[0] comes straight from the input: key_reg is not loaded yet.
      key_reg     <= bus.key;
      state_reg   <= bus.plain_txt ^ bus.key[0:BLK_W-1];
      round_idx   <= ROUND_W'(1);
      busy        <= 1'b1;
      out_valid_q <= 1'b0;
      state       <= RUN;
    end else begin
      case (state)
        RUN: begin
          state_reg <= round_out;
          if (round_idx == LAST_RND) begin
            cipher_q    <= round_out;
            out_valid_q <= 1'b1;
            round_idx   <= '0;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            round_idx <= round_idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed FIPS-197 vectors against 128/192/256-bit builds of the sequencer.
module tb_aes_round_sequencer;
  import aes_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_round_sequencer_if #(.key_length(128)) b128 ();
  aes_round_sequencer_if #(.key_length(192)) b192 ();
  aes_round_sequencer_if #(.key_length(256)) b256 ();

  logic       busy128, busy192, busy256;
  logic [3:0] ridx128, ridx192, ridx256;
`ifdef AES_SEQ_ABORT_EN
  logic abort = 1'b0;
  logic abort_off = 1'b0;
`endif

  aes_round_sequencer #(.key_length(128)) dut128 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_SEQ_ABORT_EN
    .abort(abort),
`endif
    .bus(b128), .busy(busy128), .round_idx(ridx128));
  aes_round_sequencer #(.key_length(192)) dut192 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_SEQ_ABORT_EN
    .abort(abort_off),
`endif
    .bus(b192), .busy(busy192), .round_idx(ridx192));
  aes_round_sequencer #(.key_length(256)) dut256 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_SEQ_ABORT_EN
    .abort(abort_off),
`endif
    .bus(b256), .busy(busy256), .round_idx(ridx256));

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single block with out_ready held high: latency, busy width, ciphertext.
  task automatic run128(input vec_t v, input int tag);
    int n, nb;
    b128.key = v.key; b128.plain_txt = v.pt;
    b128.in_valid = 1'b1; b128.out_ready = 1'b1;
    #1;
    chk($sformatf("in_ready_%0d", tag), 128'(b128.in_ready), 128'd1);
    tick;
    b128.in_valid = 1'b0;
    n = 0; nb = 0;
    while (!b128.out_valid && n < 40) begin
      if (busy128) nb++;
      tick;
      n++;
    end
    chk($sformatf("latency_%0d", tag), 128'(n), 128'd10);
    chk($sformatf("busy_cycles_%0d", tag), 128'(nb), 128'd10);
    chk($sformatf("ct_%0d", tag), b128.cipher_txt, v.ct);
    chk($sformatf("busy_done_%0d", tag), 128'(busy128), 128'd0);
    tick;
    chk($sformatf("ov_clear_%0d", tag), 128'(b128.out_valid), 128'd0);
    chk($sformatf("idle_ready_%0d", tag), 128'(b128.in_ready), 128'd1);
  endtask

  initial begin
    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                pt:  128'h00112233445566778899aabbccddeeff,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{key: 128'h0,
                pt:  128'h0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    b128.in_valid = 0; b128.out_ready = 0; b128.key = '0; b128.plain_txt = '0;
    b192.in_valid = 0; b192.out_ready = 1; b192.plain_txt = '0;
    b192.key = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    b256.in_valid = 0; b256.out_ready = 1; b256.plain_txt = '0;
    b256.key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    tick; tick;
    chk("rst_out_valid", 128'(b128.out_valid), 128'd0);
    chk("rst_busy", 128'(busy128), 128'd0);
    chk("rst_round_idx", 128'(ridx128), 128'd0);
    chk("rst_cipher", b128.cipher_txt, 128'd0);
    chk("rst_in_ready", 128'(b128.in_ready), 128'd1);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 3; i++) run128(vecs[i], i);

    // 192- and 256-bit keys, launched together.
    b192.plain_txt = 128'h00112233445566778899aabbccddeeff;
    b256.plain_txt = 128'h00112233445566778899aabbccddeeff;
    b192.in_valid = 1; b256.in_valid = 1;
    tick;
    b192.in_valid = 0; b256.in_valid = 0;
    for (int k = 1; k <= 14; k++) begin
      tick;
      if (k == 11) chk("ov192_early", 128'(b192.out_valid), 128'd0);
      if (k == 12) begin
        chk("ov192", 128'(b192.out_valid), 128'd1);
        chk("ct192", b192.cipher_txt, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
      end
      if (k == 13) chk("ov256_early", 128'(b256.out_valid), 128'd0);
      if (k == 14) begin
        chk("ov256", 128'(b256.out_valid), 128'd1);
        chk("ct256", b256.cipher_txt, 128'h8ea2b7ca516745bfeafc49904b496089);
      end
    end

    // Backpressure: result held, new input refused until out_ready.
    b128.key = vecs[1].key; b128.plain_txt = vecs[1].pt;
    b128.in_valid = 1; b128.out_ready = 0;
    tick;
    b128.in_valid = 0;
    for (int k = 0; k < 10; k++) tick;
    b128.key = vecs[2].key; b128.plain_txt = vecs[2].pt; b128.in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_ov_%0d", k), 128'(b128.out_valid), 128'd1);
      chk($sformatf("bp_ct_%0d", k), b128.cipher_txt, vecs[1].ct);
      chk($sformatf("bp_in_ready_%0d", k), 128'(b128.in_ready), 128'd0);
      tick;
    end
    b128.in_valid = 0; b128.out_ready = 1;
    #1;
    chk("bp_in_ready_release", 128'(b128.in_ready), 128'd1);
    tick;
    chk("bp_ov_clear", 128'(b128.out_valid), 128'd0);
    chk("bp_busy_idle", 128'(busy128), 128'd0);

    // Back-to-back: second accept lands on the first output handshake.
    b128.key = vecs[0].key; b128.plain_txt = vecs[0].pt;
    b128.in_valid = 1; b128.out_ready = 1;
    tick;
    b128.key = vecs[2].key; b128.plain_txt = vecs[2].pt;
    for (int k = 0; k < 9; k++) tick;
    chk("b2b_ov_early", 128'(b128.out_valid), 128'd0);
    tick;
    chk("b2b_ov_a", 128'(b128.out_valid), 128'd1);
    chk("b2b_ct_a", b128.cipher_txt, vecs[0].ct);
    chk("b2b_in_ready", 128'(b128.in_ready), 128'd1);
    tick;
    b128.in_valid = 0;
    chk("b2b_ov_drop", 128'(b128.out_valid), 128'd0);
    chk("b2b_busy_b", 128'(busy128), 128'd1);
    chk("b2b_ridx_b", 128'(ridx128), 128'd1);
    for (int k = 0; k < 9; k++) tick;
    chk("b2b_ov_b_early", 128'(b128.out_valid), 128'd0);
    tick;
    chk("b2b_ov_b", 128'(b128.out_valid), 128'd1);
    chk("b2b_ct_b", b128.cipher_txt, vecs[2].ct);
    tick;

    // Reset mid-run at round 5, then a fresh block.
    b128.key = vecs[0].key; b128.plain_txt = vecs[0].pt; b128.in_valid = 1;
    tick;
    b128.in_valid = 0;
    for (int k = 0; k < 4; k++) tick;
    chk("mid_ridx", 128'(ridx128), 128'd5);
    rst_n = 1'b0;
    tick;
    chk("mid_rst_ov", 128'(b128.out_valid), 128'd0);
    chk("mid_rst_ct", b128.cipher_txt, 128'd0);
    chk("mid_rst_in_ready", 128'(b128.in_ready), 128'd1);
    chk("mid_rst_busy", 128'(busy128), 128'd0);
    chk("mid_rst_ridx", 128'(ridx128), 128'd0);
    rst_n = 1'b1;
    run128(vecs[1], 10);

`ifdef AES_SEQ_ABORT_EN
    begin
      int seen;
      b128.key = vecs[0].key; b128.plain_txt = vecs[0].pt; b128.in_valid = 1;
      tick;
      b128.in_valid = 0;
      tick; tick;
      chk("ab_ridx3", 128'(ridx128), 128'd3);
      abort = 1;
      #1;
      chk("ab_in_ready_low", 128'(b128.in_ready), 128'd0);
      tick;
      chk("ab_busy", 128'(busy128), 128'd0);
      chk("ab_ridx", 128'(ridx128), 128'd0);
      abort = 0;
      #1;
      chk("ab_in_ready_back", 128'(b128.in_ready), 128'd1);
      seen = 0;
      for (int k = 0; k < 15; k++) begin
        if (b128.out_valid) seen = 1;
        tick;
      end
      chk("ab_no_ov", 128'(seen), 128'd0);

      b128.in_valid = 1; b128.out_ready = 0;
      tick;
      b128.in_valid = 0;
      for (int k = 0; k < 10; k++) tick;
      chk("ab_done_ov", 128'(b128.out_valid), 128'd1);
      b128.key = vecs[2].key; b128.plain_txt = vecs[2].pt;
      b128.in_valid = 1; b128.out_ready = 1; abort = 1;
      tick;
      abort = 0; b128.in_valid = 0;
      chk("ab_done_ov_clr", 128'(b128.out_valid), 128'd0);
      chk("ab_done_no_accept", 128'(busy128), 128'd0);
      chk("ab_done_ridx", 128'(ridx128), 128'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
